// File: rtl/fft_output_reorder.sv
// fft_output_reorder: ping-pong frame buffer between fft_block and a
// valid/ready consumer. Each 16-sample frame is collected in one bank and then
// drained while the other bank fills.
// Optional feature: define FFT_REORDER_BITREV_EN to read each bank in
// bit-reversed address order (natural bin order from a bit-reversed stream).
// Without it the block is a plain double buffer in arrival order.
module fft_output_reorder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_PTS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_i,
    output logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_i,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic              ovf_err
);

    localparam int unsigned CNT_W = $clog2(N_PTS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PTS - 1);

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

    // Sample storage; never reset, contents are only visible while a bank is full
    logic [DATA_W-1:0] mem_r [2][N_PTS];
    logic [DATA_W-1:0] mem_i [2][N_PTS];

    logic [1:0]       bank_full, bank_full_n;
    logic             wr_bank, wr_bank_n;
    logic [CNT_W-1:0] wr_cnt, wr_cnt_n;
    logic             rd_bank, rd_bank_n;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_n;
    logic             ovf_err_n;
    logic             wr_fire;
    logic [CNT_W-1:0] rd_addr;
    rd_state_t        rd_state;

    // The read FSM state is the fullness of the bank being read
    assign rd_state  = bank_full[rd_bank] ? RD_DRAIN : RD_IDLE;
    assign stall     = bank_full[wr_bank];
    assign out_valid = (rd_state == RD_DRAIN);
    assign out_last  = out_valid && (rd_cnt == LAST_CNT);
    assign out_idx   = 4'(rd_cnt);
    assign out_r     = mem_r[rd_bank][rd_addr];
    assign out_i     = mem_i[rd_bank][rd_addr];

    // Read address: bit-reversed counter or straight counter
    always_comb begin
        rd_addr = rd_cnt;
`ifdef FFT_REORDER_BITREV_EN
        for (int b = 0; b < int'(CNT_W); b++) begin
            rd_addr[b] = rd_cnt[int'(CNT_W) - 1 - b];
        end
`endif
    end

    // Next-state logic for write and read pointers, bank flags and overflow flag
    always_comb begin
        bank_full_n = bank_full;
        wr_bank_n   = wr_bank;
        wr_cnt_n    = wr_cnt;
        rd_bank_n   = rd_bank;
        rd_cnt_n    = rd_cnt;
        ovf_err_n   = ovf_err;
        wr_fire     = in_valid && !bank_full[wr_bank];

        if (in_valid && bank_full[wr_bank]) begin
            ovf_err_n = 1'b1;
        end

        if (wr_fire) begin
            if (wr_cnt == LAST_CNT) begin
                bank_full_n[wr_bank] = 1'b1;
                wr_bank_n            = ~wr_bank;
                wr_cnt_n             = '0;
            end else begin
                wr_cnt_n = wr_cnt + CNT_W'(1);
            end
        end

        // Write completion and read completion always hit different banks
        case (rd_state)
            RD_IDLE: begin
            end
            RD_DRAIN: begin
                if (out_ready) begin
                    if (rd_cnt == LAST_CNT) begin
                        bank_full_n[rd_bank] = 1'b0;
                        rd_bank_n            = ~rd_bank;
                        rd_cnt_n             = '0;
                    end else begin
                        rd_cnt_n = rd_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            ovf_err   <= 1'b0;
        end else begin
            bank_full <= bank_full_n;
            wr_bank   <= wr_bank_n;
            wr_cnt    <= wr_cnt_n;
            rd_bank   <= rd_bank_n;
            rd_cnt    <= rd_cnt_n;
            ovf_err   <= ovf_err_n;
        end
    end

    // Bank write port; gated off by reset so a reset cycle stores nothing
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem_r[wr_bank][wr_cnt] <= in_r;
            mem_i[wr_bank][wr_cnt] <= in_i;
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: randomized scoreboard bench for fft_output_reorder.
// The reference model gathers accepted samples into frames and, per frame,
// queues the 16 expected outputs in bin order; a monitor pops on handshakes.
module tb_fft_output_reorder;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_r, in_i;
    logic         stall, out_valid, out_ready, out_last, ovf_err;
    logic [W-1:0] out_r, out_i;
    logic [3:0]   out_idx;

    fft_output_reorder #(.DATA_W(W), .N_PTS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_r     (in_r),
        .in_i     (in_i),
        .stall    (stall),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_i    (out_i),
        .out_idx  (out_idx),
        .out_last (out_last),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    exp_t           exp_q[$];
    logic [2*W-1:0] fbuf[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Window statistics for the back-to-back test
    int cyc = 0;
    int vcount = 0;
    int first_v = -1;
    int last_v = -1;
    bit stall_seen = 1'b0;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_eq(input string name, input longint act, input longint exp);
        chk(name, act == exp, act, exp);
    endtask

    function automatic int bin_addr(input int k);
        int r = 0;
        int x = k;
`ifdef FFT_REORDER_BITREV_EN
        for (int b = 0; b < 4; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
`else
        r = x;
        return r;
`endif
    endfunction

    // Reference model: gather accepted samples, emit a frame's outputs once complete
    always @(negedge clk) begin
        if (rst) begin
            fbuf.delete();
            exp_q.delete();
        end else if (in_valid && !stall) begin
            fbuf.push_back({in_r, in_i});
            if (fbuf.size() == 16) begin
                for (int k = 0; k < 16; k++) begin
                    exp_t e;
                    e.r    = fbuf[bin_addr(k)][2*W-1:W];
                    e.i    = fbuf[bin_addr(k)][W-1:0];
                    e.idx  = 4'(k);
                    e.last = (k == 15);
                    exp_q.push_back(e);
                end
                fbuf.delete();
            end
        end
    end

    // Monitor: compare each handshake against the scoreboard and check holding
    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_r, hold_i;
    logic [3:0]   hold_idx;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                chk_eq("hold_while_not_ready", {out_valid, out_r, out_i, out_idx},
                       {1'b1, hold_r, hold_i, hold_idx});
            hold_pend = out_valid && !out_ready;
            hold_r    = out_r;
            hold_i    = out_i;
            hold_idx  = out_idx;
            if (stall) stall_seen = 1'b1;
            if (out_valid) begin
                vcount++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1'b0, {out_r, out_i}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk_eq("output_sample", {out_r, out_i, out_idx, out_last}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample until accepted, bounded
    task automatic send(input logic [W-1:0] r, input logic [W-1:0] i);
        bit acc;
        int t = 0;
        in_valid = 1'b1;
        in_r = r;
        in_i = i;
        forever begin
            @(negedge clk);
            acc = !stall;
            tick();
            if (acc) break;
            t++;
            if (t > 300) begin
                chk("send_timeout", 1'b0, t, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait for the scoreboard and DUT to empty, bounded
    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 400) begin
            tick();
            t++;
        end
        chk_eq("drain_complete", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_r = '0;
        in_i = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk_eq("reset_state", {stall, out_valid, out_last, out_idx, ovf_err}, 0);
        rst = 1'b0;
        tick();

        // One frame k = 0..15, latency to out_valid
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_r = W'(k);
            in_i = W'(-k);
            if (k == 15) chk_eq("no_early_valid", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        chk_eq("valid_after_last_input", {out_valid, out_idx}, {1'b1, 4'd0});
        drain();

        // Back-to-back random frames with out_ready held high
        vcount = 0;
        first_v = -1;
        last_v = -1;
        stall_seen = 1'b0;
        for (int n = 0; n < 32; n++) send(W'($urandom), W'($urandom));
        drain();
        chk_eq("b2b_stall_never", stall_seen, 0);
        chk_eq("b2b_valid_count", vcount, 32);
        chk_eq("b2b_valid_contiguous", last_v - first_v + 1, 32);

        // out_ready toggling with random input gaps
        fork
            begin
                for (int n = 0; n < 32; n++) begin
                    repeat ($urandom_range(0, 1)) tick();
                    send(W'($urandom), W'($urandom));
                end
            end
            begin
                repeat (160) begin
                    tick();
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Overflow: consumer stalled, three frames offered
        out_ready = 1'b0;
        for (int n = 0; n < 32; n++) begin
            in_valid = 1'b1;
            in_r = W'($urandom);
            in_i = W'($urandom);
            if (n == 31) chk_eq("stall_low_before_32nd", stall, 0);
            tick();
        end
        chk_eq("stall_after_32nd", stall, 1);
        chk_eq("no_ovf_yet", ovf_err, 0);
        for (int n = 0; n < 16; n++) begin
            in_r = W'($urandom);
            in_i = W'($urandom);
            tick();
            if (n == 0) chk_eq("ovf_set_on_33rd", ovf_err, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk_eq("ovf_sticky", {ovf_err, stall}, {1'b1, 1'b0});

        // Reset after 7 samples of frame 2 with frame 1 still buffered
        out_ready = 1'b0;
        for (int n = 0; n < 23; n++) send(W'($urandom), W'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("post_reset_state", {out_valid, stall, ovf_err, out_idx}, 0);
        tick();
        chk_eq("post_reset_no_stale", out_valid, 0);
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) send(W'($urandom), W'($urandom));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
